ucaspian_dendrite_sched: RTL
============================

// Module: ucaspian_dendrite_sched
// PURPOSE
//  Merges synapse-fire streams from NUM_REQ requesters into the single dendrite input port.
//  Uses round-robin arbitration and a one-entry output register.
//  Sequences timesteps: drains in-flight fires, pulses next_step, then waits for dendrite step_done.
//  Sits between the synapse engines / input-fire path and ucaspian_dendrite.
// PARAMETERS
//  NUM_REQ   4   number of fire requesters (>=2, power of 2)
//  ADDR_W    8   dendrite address width
//  CHARGE_W  9   signed charge width
//  CNT_W     16  per-step fire counter width
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 synchronous, active-high reset
//  enable         in   1                 allow new grants
//  req_addr       in   NUM_REQ*ADDR_W    packed; requester i at [i*ADDR_W +: ADDR_W]
//  req_charge     in   NUM_REQ*CHARGE_W  packed signed charges, same packing
//  req_vld        in   NUM_REQ           requester valid
//  req_rdy        out  NUM_REQ           one-hot grant/accept
//  dend_addr      out  ADDR_W            to dendrite
//  dend_charge    out  CHARGE_W          signed, to dendrite
//  dend_vld       out  1                 output register valid
//  dend_rdy       in   1                 dendrite ready
//  step_req       in   1                 request timestep advance (pulse or level)
//  next_step      out  1                 1-cycle pulse to dendrite
//  dend_step_done in   1                 dendrite flush complete
//  step_done      out  1                 1-cycle pulse when the step is fully finished
//  last_fires     out  CNT_W             fires delivered in the previous step
//  busy           out  1                 state!=RUN or dend_vld
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer=0; fire_cnt=0; step_pend=0; state=RUN.
//  Output reg loads when load_ok = !dend_vld || dend_rdy.
//   dend_vld holds until dend_rdy; addr/charge are stable while held.
//  Grant (comb): in RUN && enable && load_ok.
//   Pick the first set req_vld scanning from ptr upward (mod NUM_REQ).
//   req_rdy = that one-hot; req_rdy may depend on req_vld.
//   On grant i: reg <= req i data, dend_vld<=1, ptr <= (i+1) mod NUM_REQ. Latency 1 cycle.
//  fire_cnt: +1 on each dend_vld&&dend_rdy; saturates at all-ones.
//  step_pend: set on any step_req cycle; cleared on entering STEP.
//   Extra step_req during a step merges into one pending request.
//  FSM:
//   RUN  : if step_pend -> DRAIN (no grant that cycle).
//   DRAIN: req_rdy=0.
//    When !dend_vld, or dend_vld&&dend_rdy this cycle -> STEP.
//   STEP : next_step=1 (one cycle); last_fires<=fire_cnt; fire_cnt<=0; guard<=2 -> WAIT.
//   WAIT : req_rdy=0; guard decrements to 0.
//    dend_step_done is ignored while guard!=0 (masks stale done).
//    When guard==0 && dend_step_done: step_done=1 -> RUN.
//  enable=0: no grants; a pending output still drains; the FSM still sequences steps.
//  Reset mid-step: immediate return to RUN; the held output is dropped; no next_step emitted.
//  No requester is starved: worst-case wait is NUM_REQ-1 grants.
// STRUCTURE
//  Package ucaspian_pkg: sched_state_t enum {RUN,DRAIN,STEP,WAIT}; ADDR_W/CHARGE_W constants.
//  Sub-module ucaspian_rr_arb #(N): comb round-robin pick (vld, ptr) -> onehot, idx, any.
//  Everything else (output reg, FSM, counters) is in this module.
// TESTING
//  1. All 4 req_vld=1, dend_rdy=1 -> grants 0,1,2,3,0 on consecutive cycles; dend_vld continuous.
//  2. req1 sends addr 0x12 charge -5; dend_rdy=0 for 3 cycles.
//     -> dend_addr=0x12, dend_charge=-5 held; no further req_rdy until accepted.
//  3. 10 fires, then step_req pulse while one is held -> DRAIN until accepted; next_step 1 cycle later.
//     last_fires=10; fire_cnt cleared.
//  4. dend_step_done already high at next_step -> step_done no earlier than 3 cycles after next_step.
//     RUN resumes next cycle.
//  5. step_req pulsed twice during WAIT -> exactly one further step sequence after return to RUN.
//  6. reset asserted in WAIT with dend_vld=1 -> next cycle all outputs 0, state RUN, ptr 0.

Source files
------------

// File: rtl/ucaspian_pkg.sv
// Shared types and default widths for the uCaspian dendrite scheduler.
//   sched_state_t : timestep sequencing states
//   ADDR_W        : default dendrite address width
//   CHARGE_W      : default signed charge width
//   GUARD_INIT    : cycles during which dendrite step_done is ignored after next_step
package ucaspian_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned CHARGE_W = 9;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StStep  = 2'd2,
    StWait  = 2'd3
  } sched_state_t;

  localparam logic [1:0] GUARD_INIT = 2'd2;

endpackage

// File: rtl/ucaspian_dendrite_sched_if.sv
// Fire-request and dendrite-output bundle of the dendrite scheduler.
//   req_addr/req_charge : packed per-requester data, requester i at [i*W +: W]
//   req_vld/req_rdy     : per-requester valid and one-hot grant
//   dend_addr/charge    : registered output to the dendrite (charge is two's complement)
//   dend_vld/dend_rdy   : output handshake
// master: the side producing fires and consuming the dendrite port (synapse engines + dendrite).
// slave : the scheduler itself.
interface ucaspian_dendrite_sched_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = ucaspian_pkg::ADDR_W,
  parameter int unsigned CHARGE_W = ucaspian_pkg::CHARGE_W
);

  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*CHARGE_W-1:0] req_charge;
  logic [NUM_REQ-1:0]          req_vld;
  logic [NUM_REQ-1:0]          req_rdy;
  logic [ADDR_W-1:0]           dend_addr;
  logic [CHARGE_W-1:0]         dend_charge;
  logic                        dend_vld;
  logic                        dend_rdy;

  modport master (
    output req_addr, req_charge, req_vld, dend_rdy,
    input  req_rdy, dend_addr, dend_charge, dend_vld
  );

  modport slave (
    input  req_addr, req_charge, req_vld, dend_rdy,
    output req_rdy, dend_addr, dend_charge, dend_vld
  );

endinterface

// File: rtl/ucaspian_rr_arb.sv
// Combinational round-robin pick.
//   vld    : request vector
//   ptr    : highest-priority index for this cycle
//   onehot : selected request (all zero if none)
//   idx    : binary index of the selection
//   any    : at least one request is set
// N must be a power of two so the scan wraps by plain overflow.
module ucaspian_rr_arb #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    vld,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  logic [IdxW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IdxW'(k);
      if (!any && vld[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    onehot[idx] = any;
  end

endmodule

// File: rtl/ucaspian_dendrite_sched.sv
// Merges NUM_REQ synapse-fire streams into the single dendrite input port and sequences
// timesteps (drain in-flight fire, pulse next_step, wait for the dendrite to finish).
//   clk, reset     : clock, synchronous active-high reset
//   enable         : allow new grants
//   bus            : request/grant and dendrite output handshake (slave side)
//   step_req       : timestep advance request (pulse or level)
//   next_step      : 1-cycle pulse to the dendrite
//   dend_step_done : dendrite flush complete
//   step_done      : 1-cycle pulse when the step has fully finished
//   last_fires     : fires delivered during the previous step
//   busy           : sequencing a step or holding an undelivered fire
module ucaspian_dendrite_sched #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = ucaspian_pkg::ADDR_W,
  parameter int unsigned CHARGE_W = ucaspian_pkg::CHARGE_W,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  ucaspian_dendrite_sched_if.slave      bus,
  input  logic                          step_req,
  output logic                          next_step,
  input  logic                          dend_step_done,
  output logic                          step_done,
  output logic [CNT_W-1:0]              last_fires,
  output logic                          busy
);

  import ucaspian_pkg::*;

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  sched_state_t state_q, state_d;

  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic                dend_vld_q, dend_vld_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CHARGE_W-1:0] charge_q, charge_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    last_q, last_d;
  logic                pend_q, pend_d;
  logic [1:0]          guard_q, guard_d;

  logic                arb_any;
  logic [NUM_REQ-1:0]  arb_onehot;
  logic [PtrW-1:0]     arb_idx;
  logic                load_ok;
  logic                fire;
  logic                grant_en;
  logic                grant_ok;
  logic                grant;
  logic                enter_step;

  ucaspian_rr_arb #(
    .N (NUM_REQ)
  ) u_arb (
    .vld    (bus.req_vld),
    .ptr    (ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // The output register may reload when empty or being drained this same cycle.
  assign load_ok  = !dend_vld_q || bus.dend_rdy;
  assign fire     = dend_vld_q && bus.dend_rdy;
  assign grant_ok = grant_en && load_ok;
  assign grant    = grant_ok && arb_any;

  assign bus.req_rdy     = grant_ok ? arb_onehot : '0;
  assign bus.dend_vld    = dend_vld_q;
  assign bus.dend_addr   = addr_q;
  assign bus.dend_charge = charge_q;
  assign last_fires      = last_q;
  assign busy            = (state_q != StRun) || dend_vld_q;

  // Step sequencing and comb outputs.
  always_comb begin
    state_d    = state_q;
    next_step  = 1'b0;
    step_done  = 1'b0;
    grant_en   = 1'b0;
    enter_step = 1'b0;
    case (state_q)
      StRun: begin
        // A pending step blocks the grant in the same cycle it is acted on.
        if (pend_q) state_d = StDrain;
        else        grant_en = enable;
      end
      StDrain: begin
        if (!dend_vld_q || bus.dend_rdy) begin
          state_d    = StStep;
          enter_step = 1'b1;
        end
      end
      StStep: begin
        next_step = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        // A done still high from the previous step is masked until guard expires.
        if (guard_q == '0 && dend_step_done) begin
          step_done = 1'b1;
          state_d   = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    // Nothing is granted or pulsed while reset is held.
    if (reset) begin
      grant_en  = 1'b0;
      next_step = 1'b0;
      step_done = 1'b0;
    end
  end

  // Output register, pointer, counters.
  always_comb begin
    dend_vld_d = dend_vld_q;
    addr_d     = addr_q;
    charge_d   = charge_q;
    ptr_d      = ptr_q;
    if (grant) begin
      dend_vld_d = 1'b1;
      addr_d     = bus.req_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
      charge_d   = bus.req_charge[32'(arb_idx)*CHARGE_W +: CHARGE_W];
      ptr_d      = arb_idx + PtrW'(1);
    end else if (bus.dend_rdy) begin
      dend_vld_d = 1'b0;
    end

    cnt_d  = cnt_q;
    last_d = last_q;
    if (state_q == StStep) begin
      last_d = cnt_q;
      cnt_d  = '0;
    end else if (fire && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    guard_d = guard_q;
    if (state_q == StStep) begin
      guard_d = GUARD_INIT;
    end else if (state_q == StWait && guard_q != '0) begin
      guard_d = guard_q - 1'b1;
    end

    // Requests arriving while a step is in progress merge into one pending request.
    pend_d = step_req | (pend_q & ~enter_step);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      ptr_q      <= '0;
      dend_vld_q <= 1'b0;
      addr_q     <= '0;
      charge_q   <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      pend_q     <= 1'b0;
      guard_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dend_vld_q <= dend_vld_d;
      addr_q     <= addr_d;
      charge_q   <= charge_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      guard_q    <= guard_d;
    end
  end

endmodule
